// File: rtl/alu_seq_pkg.sv
// Shared control-bundle layout and FSM encodings for the sequential Hack ALU.
package alu_seq_pkg;

  typedef struct packed {
    logic zx;
    logic nx;
    logic zy;
    logic ny;
    logic f;
    logic no;
  } hack_t;

  typedef struct packed {
    hack_t fn;
    logic  mul;
  } ctrl_t;

  typedef logic [0:0] state_t;
  localparam state_t ST_IDLE = 1'b0;
  localparam state_t ST_MUL  = 1'b1;

endpackage

// File: rtl/alu_core.sv
// Combinational Hack ALU: zero/negate operand preprocessing, then add-or-and, then optional invert.
// Latency 0 (pure combinational).
// No flow control; the caller decides when the outputs are consumed.
module alu_core
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  hack_t            fn,
  output logic [WIDTH-1:0] xp,
  output logic [WIDTH-1:0] yp,
  output logic [WIDTH-1:0] res,
  output logic             cout
);

  logic [WIDTH-1:0] xz;
  logic [WIDTH-1:0] yz;
  logic [WIDTH-1:0] r;
  logic [WIDTH:0]   sum;

  always_comb begin
    xz   = fn.zx ? '0 : x;
    yz   = fn.zy ? '0 : y;
    xp   = fn.nx ? ~xz : xz;
    yp   = fn.ny ? ~yz : yz;
    sum  = {1'b0, xp} + {1'b0, yp};
    r    = fn.f ? sum[WIDTH-1:0] : (xp & yp);
    cout = fn.f & sum[WIDTH];
    res  = fn.no ? ~r : r;
  end

endmodule

// File: rtl/alu_seq.sv
// Registered Hack ALU with carry flag and an iterative shift-add multiply mode.
// Latency: 1 cycle for ALU ops, WIDTH+1 cycles from accept to out_valid for multiply.
// in_ready drops while a multiply runs; requests then are dropped, and out_valid has no backpressure.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             zx,
  input  logic             nx,
  input  logic             zy,
  input  logic             ny,
  input  logic             f,
  input  logic             no,
  input  logic             mul,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  output logic             zr,
  output logic             ng,
  output logic             cv
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  hack_t            fn;
  logic [WIDTH-1:0] core_xp;
  logic [WIDTH-1:0] core_yp;
  logic [WIDTH-1:0] core_res;
  logic             core_cout;

  state_t             state;
  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_next;
  logic [WIDTH-1:0]   mplier;
  logic [CNT_W-1:0]   cnt;
  logic               no_q;
  logic [WIDTH-1:0]   mul_res;

  assign fn = {zx, nx, zy, ny, f, no};

  alu_core #(.WIDTH(WIDTH)) u_core (
    .x    (x),
    .y    (y),
    .fn   (fn),
    .xp   (core_xp),
    .yp   (core_yp),
    .res  (core_res),
    .cout (core_cout)
  );

  assign in_ready = (state == ST_IDLE);

  // The last iteration's partial sum is the product, so the result is taken from acc_next.
  assign acc_next = mplier[0] ? (acc + mcand) : acc;
  assign mul_res  = no_q ? ~acc_next[WIDTH-1:0] : acc_next[WIDTH-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      mcand     <= '0;
      acc       <= '0;
      mplier    <= '0;
      cnt       <= '0;
      no_q      <= 1'b0;
      out       <= '0;
      zr        <= 1'b0;
      ng        <= 1'b0;
      cv        <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (state == ST_IDLE) begin
        if (in_valid) begin
          if (mul) begin
            mcand  <= {{WIDTH{1'b0}}, core_xp};
            mplier <= core_yp;
            acc    <= '0;
            cnt    <= '0;
            no_q   <= no;
            state  <= ST_MUL;
          end else begin
            out       <= core_res;
            zr        <= (core_res == '0);
            ng        <= core_res[WIDTH-1];
            cv        <= core_cout;
            out_valid <= 1'b1;
          end
        end
      end else begin
        acc    <= acc_next;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + CNT_W'(1);
        if (cnt == CNT_LAST) begin
          out       <= mul_res;
          zr        <= (mul_res == '0);
          ng        <= mul_res[WIDTH-1];
          cv        <= |acc_next[2*WIDTH-1:WIDTH];
          out_valid <= 1'b1;
          state     <= ST_IDLE;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed and randomized bench for alu_seq against an arithmetic reference model.
module tb_alu_seq;

  localparam int W = 16;

  localparam logic [6:0] C_ADD  = 7'b0000100;
  localparam logic [6:0] C_SUB  = 7'b0100110;
  localparam logic [6:0] C_ZERO = 7'b1010000;
  localparam logic [6:0] C_MUL  = 7'b0000001;
  localparam logic [6:0] C_MULN = 7'b0000011;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] x;
  logic [W-1:0] y;
  logic         zx, nx, zy, ny, f, no, mul;
  logic [W-1:0] out;
  logic         out_valid;
  logic         zr, ng, cv;

  int n_checks = 0;
  int n_pass   = 0;

  alu_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
    .zx        (zx),
    .nx        (nx),
    .zy        (zy),
    .ny        (ny),
    .f         (f),
    .no        (no),
    .mul       (mul),
    .out       (out),
    .out_valid (out_valid),
    .zr        (zr),
    .ng        (ng),
    .cv        (cv)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h at %0t", nm, act, exp, $time);
  endtask

  // Reference model: results computed with plain arithmetic, multiply as one product.
  logic [W-1:0]       m_out = '0;
  logic               m_zr = 1'b0, m_ng = 1'b0, m_cv = 1'b0, m_vld = 1'b0;
  bit                 pend = 0;
  int                 edge_n = 0;
  int                 done_edge = 0;
  logic [W-1:0]       p_out;
  logic               p_cv;
  logic [W-1:0]       mxp, myp, mr;
  longint unsigned    prod;
  int unsigned        sum;

  function automatic logic [W-1:0] pre(input logic [W-1:0] v, input logic z, input logic n);
    logic [W-1:0] t;
    t = z ? '0 : v;
    return n ? ~t : t;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_out = '0; m_zr = 0; m_ng = 0; m_cv = 0; m_vld = 0; pend = 0;
    end else begin
      m_vld = 0;
      if (pend) begin
        if (edge_n == done_edge) begin
          m_out = p_out; m_zr = (p_out == 0); m_ng = p_out[W-1]; m_cv = p_cv;
          m_vld = 1; pend = 0;
        end
      end else if (in_valid) begin
        mxp = pre(x, zx, nx);
        myp = pre(y, zy, ny);
        if (mul) begin
          prod  = longint'(mxp) * longint'(myp);
          mr    = prod[W-1:0];
          p_out = no ? ~mr : mr;
          p_cv  = (prod >= (64'd1 << W));
          pend  = 1;
          done_edge = edge_n + W;
        end else begin
          if (f) begin
            sum = int'(mxp) + int'(myp);
            mr  = sum[W-1:0];
            m_cv = (sum >= (32'd1 << W));
          end else begin
            mr  = mxp & myp;
            m_cv = 0;
          end
          m_out = no ? ~mr : mr;
          m_zr = (m_out == 0); m_ng = m_out[W-1]; m_vld = 1;
        end
      end
      edge_n++;
    end
  end

  always @(negedge clk) begin
    chk("in_ready", in_ready, !pend);
    chk("out_valid", out_valid, m_vld);
    chk("out", out, m_out);
    chk("zr", zr, m_zr);
    chk("ng", ng, m_ng);
    chk("cv", cv, m_cv);
  end

  task automatic op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [6:0] c);
    in_valid = 1; x = a; y = b;
    {zx, nx, zy, ny, f, no, mul} = c;
    @(posedge clk); #1;
    in_valid = 0;
  endtask

  task automatic wait_vld(input string nm);
    bit seen = 0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1;
    end
    chk(nm, seen, 1);
  endtask

  initial begin
    int got;
    int pulses;
    reset = 1; in_valid = 0; x = '0; y = '0;
    {zx, nx, zy, ny, f, no, mul} = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out", out, 16'h0000);
    chk("rst_ready", in_ready, 1);
    chk("rst_vld", out_valid, 0);
    reset = 0;
    @(posedge clk); #1;

    op(16'd5, 16'd3, C_ADD);
    chk("add_out", out, 16'h0008);
    chk("add_vld", out_valid, 1);
    chk("add_flags", {zr, ng, cv}, 3'b000);

    for (int i = 0; i < 4; i++) begin
      op(16'd3, 16'd5, C_SUB);
      chk("sub_out", out, 16'hFFFE);
      chk("sub_vld", out_valid, 1);
      chk("sub_ng_zr", {ng, zr}, 2'b10);
    end

    op(16'hFFFF, 16'h0001, C_ADD);
    chk("carry_out", out, 16'h0000);
    chk("carry_zr_cv", {zr, cv}, 2'b11);
    op(16'h1234, 16'h5678, C_ZERO);
    chk("zero_out", out, 16'h0000);
    chk("zero_zr_cv", {zr, cv}, 2'b10);

    op(16'd300, 16'd7, C_MUL);
    chk("mul_busy", in_ready, 0);
    got = -1;
    for (int k = 1; k <= 20; k++) begin
      if (k == 3) begin
        in_valid = 1; x = 16'd1; y = 16'd1; {zx, nx, zy, ny, f, no, mul} = C_ADD;
      end
      @(posedge clk); #1;
      in_valid = 0;
      if (out_valid && got < 0) got = k;
    end
    chk("mul_latency", got, 16);
    chk("mul_out", out, 16'h0834);
    chk("mul_cv", cv, 0);

    op(16'h0100, 16'h0100, C_MUL);
    wait_vld("mulov_seen");
    chk("mulov_out", out, 16'h0000);
    chk("mulov_zr_cv", {zr, cv}, 2'b11);
    op(16'h0100, 16'h0100, C_MULN);
    wait_vld("mulovn_seen");
    chk("mulovn_out", out, 16'hFFFF);
    chk("mulovn_ng_cv", {ng, cv}, 2'b11);

    op(16'd9, 16'd9, C_MUL);
    repeat (4) begin @(posedge clk); #1; end
    reset = 1; #1;
    chk("midrst_out", out, 16'h0000);
    chk("midrst_flags", {zr, ng, cv, out_valid}, 4'b0000);
    chk("midrst_ready", in_ready, 1);
    @(posedge clk); #1;
    reset = 0;
    pulses = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (out_valid) pulses++;
    end
    chk("midrst_no_vld", pulses, 0);
    op(16'd1, 16'd1, C_ADD);
    chk("post_rst_add", out, 16'h0002);

    for (int i = 0; i < 2500; i++) begin
      logic [6:0] c;
      int s;
      c = 7'($urandom);
      c[0] = ($urandom_range(0, 3) == 0);
      {zx, nx, zy, ny, f, no, mul} = c;
      s = $urandom_range(0, 3);
      x = (s == 0) ? 16'h0000 : (s == 1) ? 16'hFFFF : 16'($urandom);
      s = $urandom_range(0, 3);
      y = (s == 0) ? 16'h0000 : (s == 1) ? 16'hFFFF : 16'($urandom);
      in_valid = ($urandom_range(0, 3) != 0);
      reset = ($urandom_range(0, 199) == 0);
      @(posedge clk); #1;
    end
    reset = 0; in_valid = 0;
    repeat (30) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered successor to the combinational 16-bit Hack ALU.
- Keeps the six-bit Hack function (zx,nx,zy,ny,f,no) at a generic WIDTH and adds a carry flag.
- Adds an iterative shift-add multiply mode with a WIDTH-cycle latency.
- Operations use a valid/ready input handshake and a one-cycle result-valid pulse; the block sits between the CPU decode stage and the D/A register writeback.

Parameters:
- WIDTH, 16, datapath width in bits (≥2).
- CNT_W, $clog2(WIDTH), width of the iteration counter.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  operation request
- in_ready  out  1  block can accept; high only in IDLE
- x  in  WIDTH  operand x
- y  in  WIDTH  operand y
- zx,nx,zy,ny,f,no  in  1 each  Hack control bits
- mul  in  1  1 = multiply mode; f is ignored in this mode
- out  out  WIDTH  registered result
- out_valid  out  1  one-cycle pulse when out and the flags update
- zr  out  1  out == 0
- ng  out  1  out[WIDTH-1]
- cv  out  1  ALU mode: adder carry-out when f=1, else 0. MUL mode: unsigned overflow (product ≥ 2^WIDTH).

Behaviour:
- Reset (async, active-high):
  - state=IDLE, out=0, zr=0, ng=0, cv=0, out_valid=0, in_ready=1.
  - Internal registers cleared.
  - Any in-flight multiply is discarded and no out_valid is ever issued for it.
- Operand preprocessing, combinational at accept: xp = nx ? ~(zx?0:x) : (zx?0:x); yp likewise with zy/ny.
- Accept = in_valid & in_ready, sampled at a rising edge. Requests made while in_ready=0 are ignored, not queued.
- States: IDLE, MUL.
- IDLE, accept with mul=0:
  - r = f ? (xp+yp) mod 2^WIDTH : xp&yp; res = no ? ~r : r.
  - out=res, cv=carry-out (0 if f=0), zr/ng derived from res, out_valid=1 on the following cycle.
  - State stays IDLE, so back-to-back ALU ops are accepted every cycle. Latency 1.
- IDLE, accept with mul=1:
  - Load mcand = {WIDTH'0, xp} (2·WIDTH bits), mplier = yp, acc = 0, cnt = 0.
  - Go to MUL; in_ready=0.
- MUL, each edge:
  - If mplier[0]: acc += mcand.
  - mcand <<= 1; mplier >>= 1; cnt++.
- MUL, final iteration (the edge where cnt==WIDTH-1):
  - p = final acc; res = no ? ~p[WIDTH-1:0] : p[WIDTH-1:0].
  - cv = |p[2W-1:WIDTH]; out/zr/ng from res; out_valid=1; state → IDLE.
- MUL timing:
  - Accepted at the end of cycle c0 → out_valid in cycle c(WIDTH+1).
  - in_ready rises in c(WIDTH+1), so a new op can be accepted in the same cycle out_valid is high.
- out_valid is high for exactly one cycle per accepted op.
- out, zr, ng and cv hold their values until the next result.
- There is no output backpressure.
- Operands and control bits are captured at accept; changes on the inputs during MUL have no effect.
- Arithmetic is unsigned modulo 2^WIDTH. Two's-complement interpretation is left to the consumer; ng = MSB.
- mul=1 with yp=0: runs the full WIDTH cycles, giving p=0, so out = no ? all-ones : 0 and cv=0.

Decomposition:
- Package alu_seq_pkg: state enum (IDLE, MUL); a localparam struct/bit-positions for the control bundle {zx,nx,zy,ny,f,no,mul}.
- Sub-module alu_core: purely combinational, parametrised WIDTH. It performs the preprocessing plus the Hack function and outputs {res, cout, xp, yp}. It is reused for the accept-time preprocessing and the ALU-mode result.
- The FSM, multiply datapath and flag registers live in alu_seq.

Test Plan (WIDTH=16):
1. ALU add: x=5, y=3, all ctrl 0 except f=1 → next cycle out=0x0008, out_valid=1, zr=0, ng=0, cv=0.
2. ALU x−y: x=3, y=5, nx=1, f=1, no=1 → out=0xFFFE, ng=1, zr=0. Repeat every cycle for 4 back-to-back ops → 4 consecutive out_valid pulses, each with the correct result.
3. Carry/zero: x=0xFFFF, y=0x0001, f=1 → out=0x0000, zr=1, cv=1. Then zx=zy=1, f=0 → out=0, zr=1, cv=0.
4. MUL: x=300, y=7, mul=1 → in_ready=0 for 16 cycles; a request with in_valid=1 at cycle 3 is ignored. out=0x0834 (2100), cv=0, out_valid exactly in cycle 17 after accept.
5. MUL overflow plus no: x=0x0100, y=0x0100 → out=0, zr=1, cv=1. Same operands with no=1 → out=0xFFFF, ng=1, cv=1.
6. Reset mid-MUL: assert reset at cycle 5 of x=9, y=9 → all outputs 0 immediately, in_ready=1, no out_valid within 20 cycles. A following ALU add of 1+1 then gives out=2.
